// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception control stage: CP0 register indices,
// exception codes, the default vector and FSM state encodings.
package exc_ctrl_pkg;
  localparam logic [4:0]  CP0_STATUS     = 5'd12;
  localparam logic [4:0]  CP0_CAUSE      = 5'd13;
  localparam logic [4:0]  CP0_EPC        = 5'd14;
  localparam logic [4:0]  EXC_CODE_OV    = 5'd12;
  localparam logic [4:0]  EXC_CODE_RI    = 5'd10;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RETURN = 2'd3
  } exc_state_e;
endpackage

// File: rtl/exc_ctrl_if.sv
// Bus between main control / datapath (master) and the exception stage (slave).
interface exc_ctrl_if;
  logic        ExStrobe;
  logic        Err;
  logic        IllegalInst;
  logic [31:0] PC;
  logic        Mtc0;
  logic        Mfc0;
  logic        Eret;
  logic [4:0]  Rd;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        SquashWB;
  logic        PcLoad;
  logic [31:0] PcTarget;

  modport master (
    output ExStrobe, Err, IllegalInst, PC, Mtc0, Mfc0, Eret, Rd, WriteData,
    input  ReadData, Busy, SquashWB, PcLoad, PcTarget
  );
  modport slave (
    input  ExStrobe, Err, IllegalInst, PC, Mtc0, Mfc0, Eret, Rd, WriteData,
    output ReadData, Busy, SquashWB, PcLoad, PcTarget
  );
endinterface

// File: rtl/exc_ctrl_cp0_regs.sv
// Minimal CP0: Status.EXL, Cause.ExcCode and EPC with masked mtc0 writes
// and a combinational read mux.
module cp0_regs
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc,
  input  logic        exl_clr,
  input  logic        wr_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        exl,
  output logic [31:0] epc
);
  logic [4:0] code;

  always_ff @(posedge clk) begin
    if (reset) begin
      exl  <= 1'b0;
      code <= '0;
      epc  <= '0;
    end else if (exc_take) begin
      code <= exc_code;
      exl  <= 1'b1;
      // nested exception keeps the return address of the outer one
      if (!exl) epc <= pc;
    end else if (exl_clr) begin
      exl <= 1'b0;
    end else if (wr_en) begin
      case (rd)
        CP0_STATUS: exl  <= wdata[0];
        CP0_CAUSE:  code <= wdata[6:2];
        CP0_EPC:    epc  <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (rd)
      CP0_STATUS: rdata = {31'b0, exl};
      CP0_CAUSE:  rdata = {25'b0, code, 2'b00};
      CP0_EPC:    rdata = epc;
      default:    rdata = '0;
    endcase
  end
endmodule

// File: rtl/exc_ctrl.sv
// Exception control stage: prioritises exception/eret/mtc0 in IDLE and runs
// the FLUSH->VECTOR / RETURN sequence with registered control outputs.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [4:0]  EXC_OV     = EXC_CODE_OV,
  parameter logic [4:0]  EXC_RI     = EXC_CODE_RI
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  exc_state_e  state;
  logic        busy, squash, pc_load;
  logic [31:0] pc_target, epc;
  logic        idle, exc_req, exc_take, eret_take, wr_en;
  logic [4:0]  exc_code;

  assign idle      = (state == ST_IDLE);
  assign exc_req   = bus.ExStrobe & (bus.Err | bus.IllegalInst);
  assign exc_take  = idle & exc_req;
  assign eret_take = idle & bus.ExStrobe & bus.Eret & ~exc_req;
  // any mtc0 colliding with an exception or eret is dropped
  assign wr_en     = idle & bus.Mtc0 & ~exc_req & ~eret_take;
  assign exc_code  = bus.IllegalInst ? EXC_RI : EXC_OV;

  cp0_regs u_cp0 (
    .clk      (clk),
    .reset    (reset),
    .exc_take (exc_take),
    .exc_code (exc_code),
    .pc       (bus.PC),
    .exl_clr  (state == ST_RETURN),
    .wr_en    (wr_en),
    .rd       (bus.Rd),
    .wdata    (bus.WriteData),
    .rdata    (bus.ReadData),
    .exl      (),
    .epc      (epc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      squash    <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= EXC_VECTOR;
    end else begin
      busy      <= 1'b0;
      squash    <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= EXC_VECTOR;
      case (state)
        ST_IDLE: begin
          if (exc_take) begin
            state  <= ST_FLUSH;
            squash <= 1'b1;
            busy   <= 1'b1;
          end else if (eret_take) begin
            state     <= ST_RETURN;
            pc_load   <= 1'b1;
            pc_target <= epc;
            busy      <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state   <= ST_VECTOR;
          pc_load <= 1'b1;
          busy    <= 1'b1;
        end
        ST_VECTOR: state <= ST_IDLE;
        ST_RETURN: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.SquashWB = squash;
  assign bus.PcLoad   = pc_load;
  assign bus.PcTarget = pc_target;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: exception entry, priority, nesting, eret,
// CP0 access, collisions and reset during a flush.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  exc_ctrl_if bus ();
  exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    bus.ExStrobe = 0; bus.Err = 0; bus.IllegalInst = 0; bus.PC = '0;
    bus.Mtc0 = 0; bus.Mfc0 = 0; bus.Eret = 0; bus.Rd = '0; bus.WriteData = '0;
  endtask

  task automatic peek(input logic [4:0] r);
    bus.Rd = r; #1;
  endtask

  task automatic do_reset();
    idle_in(); reset = 1; step(); reset = 0;
  endtask

  task automatic raise(input logic err, input logic ill, input logic [31:0] pc);
    bus.ExStrobe = 1; bus.Err = err; bus.IllegalInst = ill; bus.PC = pc;
    step(); idle_in();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.Busy); end
    checks++; if (bus.SquashWB !== 1'b0) begin errors++; $display("FAIL rst_squash got %b exp 0", bus.SquashWB); end
    checks++; if (bus.PcLoad !== 1'b0) begin errors++; $display("FAIL rst_pcload got %b exp 0", bus.PcLoad); end
    checks++; if (bus.PcTarget !== 32'h8000_0180) begin errors++; $display("FAIL rst_target got %h exp 80000180", bus.PcTarget); end
    peek(12);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", bus.ReadData); end
    peek(13);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_cause got %h exp 0", bus.ReadData); end
    peek(14);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", bus.ReadData); end
  endtask

  task automatic test_overflow();
    do_reset();
    raise(1, 0, 32'h0040_0010);
    checks++; if ({bus.SquashWB, bus.Busy, bus.PcLoad} !== 3'b110) begin errors++; $display("FAIL ov_flush got %b exp 110", {bus.SquashWB, bus.Busy, bus.PcLoad}); end
    step();
    checks++; if ({bus.SquashWB, bus.Busy, bus.PcLoad} !== 3'b011) begin errors++; $display("FAIL ov_vector got %b exp 011", {bus.SquashWB, bus.Busy, bus.PcLoad}); end
    checks++; if (bus.PcTarget !== 32'h8000_0180) begin errors++; $display("FAIL ov_target got %h exp 80000180", bus.PcTarget); end
    step();
    checks++; if ({bus.SquashWB, bus.Busy, bus.PcLoad} !== 3'b000) begin errors++; $display("FAIL ov_idle got %b exp 000", {bus.SquashWB, bus.Busy, bus.PcLoad}); end
    peek(14);
    checks++; if (bus.ReadData !== 32'h0040_0010) begin errors++; $display("FAIL ov_epc got %h exp 00400010", bus.ReadData); end
    peek(13);
    checks++; if (bus.ReadData !== 32'h0000_0030) begin errors++; $display("FAIL ov_cause got %h exp 00000030", bus.ReadData); end
    peek(12);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL ov_exl got %h exp 1", bus.ReadData); end
  endtask

  task automatic test_priority();
    do_reset();
    raise(1, 1, 32'h0000_0200);
    checks++; if ({bus.SquashWB, bus.PcLoad} !== 2'b10) begin errors++; $display("FAIL pri_flush got %b exp 10", {bus.SquashWB, bus.PcLoad}); end
    step();
    checks++; if ({bus.SquashWB, bus.PcLoad} !== 2'b01) begin errors++; $display("FAIL pri_vector got %b exp 01", {bus.SquashWB, bus.PcLoad}); end
    step();
    checks++; if ({bus.Busy, bus.SquashWB, bus.PcLoad} !== 3'b000) begin errors++; $display("FAIL pri_idle got %b exp 000", {bus.Busy, bus.SquashWB, bus.PcLoad}); end
    peek(13);
    checks++; if (bus.ReadData !== 32'h0000_0028) begin errors++; $display("FAIL pri_cause got %h exp 00000028", bus.ReadData); end
  endtask

  task automatic test_nested();
    do_reset();
    raise(1, 0, 32'h0000_0100); step(); step();
    raise(0, 1, 32'h0000_0180);
    checks++; if (bus.SquashWB !== 1'b1) begin errors++; $display("FAIL nest_flush got %b exp 1", bus.SquashWB); end
    step();
    checks++; if (bus.PcLoad !== 1'b1 || bus.PcTarget !== 32'h8000_0180) begin errors++; $display("FAIL nest_vector got %b/%h exp 1/80000180", bus.PcLoad, bus.PcTarget); end
    step();
    peek(14);
    checks++; if (bus.ReadData !== 32'h0000_0100) begin errors++; $display("FAIL nest_epc got %h exp 00000100", bus.ReadData); end
    peek(13);
    checks++; if (bus.ReadData !== 32'h0000_0028) begin errors++; $display("FAIL nest_cause got %h exp 00000028", bus.ReadData); end
  endtask

  task automatic test_eret();
    do_reset();
    bus.Mtc0 = 1; bus.Rd = 14; bus.WriteData = 32'h0040_0014; step();
    bus.Rd = 12; bus.WriteData = 32'h1; step(); idle_in();
    peek(12);
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL eret_pre_exl got %h exp 1", bus.ReadData); end
    bus.ExStrobe = 1; bus.Eret = 1; step(); idle_in();
    checks++; if (bus.PcLoad !== 1'b1 || bus.Busy !== 1'b1 || bus.SquashWB !== 1'b0) begin errors++; $display("FAIL eret_ret got %b%b%b exp 110", bus.PcLoad, bus.Busy, bus.SquashWB); end
    checks++; if (bus.PcTarget !== 32'h0040_0014) begin errors++; $display("FAIL eret_target got %h exp 00400014", bus.PcTarget); end
    step();
    peek(12);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL eret_exl got %h exp 0", bus.ReadData); end
    checks++; if (bus.PcLoad !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL eret_idle got %b%b exp 00", bus.PcLoad, bus.Busy); end
  endtask

  task automatic test_cp0();
    do_reset();
    bus.Mtc0 = 1; bus.Rd = 14; bus.WriteData = 32'hDEAD_BEEF; step(); bus.Mtc0 = 0;
    checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cp0_epc got %h exp deadbeef", bus.ReadData); end
    bus.Mtc0 = 1; bus.Rd = 13; bus.WriteData = 32'hFFFF_FFFF; step(); bus.Mtc0 = 0;
    checks++; if (bus.ReadData !== 32'h0000_007C) begin errors++; $display("FAIL cp0_cause got %h exp 0000007c", bus.ReadData); end
    bus.Mtc0 = 1; bus.Rd = 12; step(); bus.Mtc0 = 0;
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL cp0_status got %h exp 1", bus.ReadData); end
    bus.Mtc0 = 1; bus.Rd = 5; step(); bus.Mtc0 = 0;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL cp0_unmapped got %h exp 0", bus.ReadData); end
  endtask

  task automatic test_collisions();
    do_reset();
    // exception and mtc0 EPC together: write dropped, EPC = faulting PC
    bus.Mtc0 = 1; bus.Rd = 14; bus.WriteData = 32'h0000_1234;
    raise(1, 0, 32'h0000_0300);
    // mtc0 during FLUSH is ignored
    bus.Mtc0 = 1; bus.Rd = 14; bus.WriteData = 32'h0000_5678; step(); idle_in(); step();
    peek(14);
    checks++; if (bus.ReadData !== 32'h0000_0300) begin errors++; $display("FAIL col_epc got %h exp 00000300", bus.ReadData); end
    // eret with mtc0 Status=1: eret wins, EXL ends cleared
    bus.ExStrobe = 1; bus.Eret = 1; bus.Mtc0 = 1; bus.Rd = 12; bus.WriteData = 32'h1; step(); idle_in();
    checks++; if (bus.PcLoad !== 1'b1 || bus.PcTarget !== 32'h0000_0300) begin errors++; $display("FAIL col_eret got %b/%h exp 1/00000300", bus.PcLoad, bus.PcTarget); end
    step(); peek(12);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL col_exl got %h exp 0", bus.ReadData); end
    // eret with an exception request: exception taken
    bus.Eret = 1;
    raise(1, 0, 32'h0000_0400);
    checks++; if ({bus.SquashWB, bus.PcLoad} !== 2'b10) begin errors++; $display("FAIL col_exc_eret got %b exp 10", {bus.SquashWB, bus.PcLoad}); end
    step(); step();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    raise(1, 0, 32'h0000_0500);
    checks++; if (bus.SquashWB !== 1'b1) begin errors++; $display("FAIL rmf_flush got %b exp 1", bus.SquashWB); end
    reset = 1; step(); reset = 0;
    checks++; if ({bus.Busy, bus.SquashWB, bus.PcLoad} !== 3'b000) begin errors++; $display("FAIL rmf_idle got %b exp 000", {bus.Busy, bus.SquashWB, bus.PcLoad}); end
    step();
    checks++; if (bus.PcLoad !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL rmf_nopc got %b%b exp 00", bus.PcLoad, bus.Busy); end
    peek(14);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rmf_epc got %h exp 0", bus.ReadData); end
    peek(12);
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rmf_exl got %h exp 0", bus.ReadData); end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_overflow();
    test_priority();
    test_nested();
    test_eret();
    test_cp0();
    test_collisions();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control stage of the multicycle CPU. Consumes the arithmetic-overflow flag from the error detector and an illegal-instruction flag from decode, and records the exception in a minimal CP0 (Status, Cause, EPC). It then runs a short FSM that squashes the faulting instruction's writeback and redirects the PC to the exception vector. Also serves `mfc0`/`mtc0` and `eret`.

## Interface
Parameters:
- `EXC_VECTOR`, default `32'h8000_0180`: PC loaded on exception entry.
- `EXC_OV`, default `5'd12`: Cause.ExcCode for overflow.
- `EXC_RI`, default `5'd10`: Cause.ExcCode for illegal instruction.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `ExStrobe` input 1: high in the ALU-execute cycle of the current instruction; `Err` and `IllegalInst` are sampled only then.
- `Err` input 1: overflow flag from the error detector.
- `IllegalInst` input 1: undefined opcode/funct from decode, held to the execute cycle.
- `PC` input 32: address of the instruction in execute.
- `Mtc0` input 1: write CP0 register `Rd` with `WriteData` this cycle.
- `Mfc0` input 1: read request. `ReadData` is combinational, so this input is informational.
- `Eret` input 1: return from exception, valid in the execute cycle.
- `Rd` input 5: CP0 register index (12 Status, 13 Cause, 14 EPC).
- `WriteData` input 32: `mtc0` data.
- `ReadData` output 32: CP0[`Rd`]. Unmapped indices read 0.
- `Busy` output 1: main control must hold its state while high.
- `SquashWB` output 1: suppress register-file and memory write of the faulting instruction.
- `PcLoad` output 1: force `PC <= PcTarget`.
- `PcTarget` output 32: `EXC_VECTOR` or EPC.

## Operation
- CP0 state:
  - Status: bit0 EXL only; other bits read 0.
  - Cause: bits[6:2] ExcCode; other bits read 0.
  - EPC: 32 bits.
- Exception request in IDLE: `ExStrobe & (Err | IllegalInst)`.
- Priority: `IllegalInst` over `Err`. With both set, ExcCode = `EXC_RI`.
- On a request, at the sampling edge:
  - Cause.ExcCode is written.
  - EXL is set to 1.
  - EPC is written with `PC` only if EXL was 0. A nested exception keeps the original EPC but still updates Cause and vectors.
- FSM states: IDLE, FLUSH, VECTOR, RETURN.
  - IDLE → FLUSH on an exception request.
  - IDLE → RETURN on `ExStrobe & Eret` with no exception request.
  - FLUSH → VECTOR unconditionally.
  - VECTOR → IDLE unconditionally.
  - RETURN → IDLE unconditionally. EXL is cleared on the RETURN→IDLE edge.
- Outputs per state:
  - FLUSH: `SquashWB=1`, `Busy=1`.
  - VECTOR: `PcLoad=1`, `PcTarget=EXC_VECTOR`, `Busy=1`.
  - RETURN: `PcLoad=1`, `PcTarget=EPC`, `Busy=1`.
  - IDLE: all three outputs 0; `PcTarget` = `EXC_VECTOR`.
- `mtc0`:
  - Status writes only EXL.
  - Cause writes only ExcCode.
  - EPC writes all 32 bits.
  - Writes take effect only in IDLE.
- Simultaneous events:
  - Exception request and `Mtc0` in the same cycle: the exception wins and the write is dropped.
  - `Eret` together with an exception request: the exception is taken and `Eret` is ignored.
  - `Mtc0` to Status and `Eret` in the same cycle: `Eret` wins.
  - All inputs are ignored outside IDLE.

## Timing
- Reset values: FSM in IDLE; `Busy`, `SquashWB`, `PcLoad` = 0; `PcTarget` = `EXC_VECTOR`; EXL=0, Cause=0, EPC=0; `ReadData` = 0 for the reset value of registers.
- Exception sampled at edge N:
  - Cycle N+1: FLUSH, `SquashWB=1`.
  - Cycle N+2: VECTOR, `PcLoad=1`.
  - Cycle N+3: IDLE.
  - Total latency: 3 cycles, `Busy` high in cycles N+1 and N+2.
- `Eret` sampled at edge N:
  - Cycle N+1: RETURN, `PcLoad=1`, `PcTarget` = EPC.
  - EXL reads 0 from cycle N+2.
- `ReadData` is combinational from the registered CP0 state. An `mtc0` at edge N is visible in cycle N+1.
- `reset` asserted in FLUSH/VECTOR/RETURN returns to IDLE at the next edge, with no `PcLoad` pulse.
- Registered state only: no output is combinational from `Err`.

## Structure
- Shared package/header holds:
  - CP0 indices 12/13/14.
  - ExcCode constants.
  - FSM state encodings.
  - The default vector.
- Sub-module `cp0_regs`: Status/Cause/EPC storage, write masking and the read mux.
- FSM and priority logic live in `exc_ctrl`.

## Test plan
- Overflow: `ExStrobe=1`, `Err=1`, `PC=0x0040_0010`.
  - Cycle N+1: `SquashWB=1`.
  - Cycle N+2: `PcLoad=1`, `PcTarget=0x8000_0180`.
  - EPC=`0x0040_0010`, Cause[6:2]=12, EXL=1.
- Priority: `Err=1` and `IllegalInst=1` together → Cause[6:2]=10; still exactly one FLUSH cycle then one VECTOR cycle.
- Nested: first exception at PC `0x100`, second at PC `0x180` with EXL=1 → EPC stays `0x100`, Cause updated, vector taken again.
- Eret: EPC=`0x0040_0014`, `Eret` pulse → next cycle `PcLoad=1`, `PcTarget=0x0040_0014`; the following cycle EXL=0.
- CP0 access:
  - `mtc0` EPC=`0xDEAD_BEEF` → `ReadData` with `Rd=14` returns `0xDEAD_BEEF` next cycle.
  - `mtc0` Cause=`0xFFFF_FFFF` → reads `0x0000_007C`.
  - `Rd=5` reads 0.
- Reset mid-flush: assert `reset` in FLUSH → next cycle IDLE, `PcLoad` never asserts, EPC=0, EXL=0.
